// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral
//   SPI mode-0 target that receives 16-bit frames (R/W, 7-bit address, 8-bit
//   data, MSB first). It holds the five 8-bit control registers that feed the
//   PWM output stage. The SPI pins are asynchronous and are synchronised
//   inside this block.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sclk, copi, ncs   SPI pins (async); ncs is active-low
//   en_reg_out_7_0    register 0x00
//   en_reg_out_15_8   register 0x01
//   en_reg_pwm_7_0    register 0x02
//   en_reg_pwm_15_8   register 0x03
//   pwm_duty_cycle    register 0x04
//   frame_err         one-cycle pulse when a frame is discarded
//   cipo              read data out (only when SPI_READBACK_EN is defined)
//
// Configuration macro: SPI_READBACK_EN adds the cipo port and register readback.
//   When it is undefined, well-formed read frames are dropped silently.
//
// Handshake: there is no valid/ready handshake. A frame is the span between a
//   synchronised ncs fall and the next ncs rise. The commit happens in the single
//   COMMIT cycle that follows the rise.

module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
`ifdef SPI_READBACK_EN
    ,
    output logic       cipo
`endif
);

    localparam int         NUM_REGS   = 5;
    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
    localparam int         S          = SYNC_STAGES;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers: SYNC_STAGES flops plus one extra flop. Bit 0 samples
    // the pin. Edges are taken from bits [S-1] and [S] only.
    // ------------------------------------------------------------------
    logic [S:0] ncs_sync_q,  ncs_sync_d;
    logic [S:0] sclk_sync_q, sclk_sync_d;
    logic [S:0] copi_sync_q, copi_sync_d;

    always_comb begin
        ncs_sync_d  = {ncs_sync_q[S-1:0],  ncs};
        sclk_sync_d = {sclk_sync_q[S-1:0], sclk};
        copi_sync_d = {copi_sync_q[S-1:0], copi};
    end

    logic ncs_fall, ncs_rise, sclk_rise, copi_bit;
    assign ncs_fall  = ncs_sync_q[S] & ~ncs_sync_q[S-1];
    assign ncs_rise  = ~ncs_sync_q[S] & ncs_sync_q[S-1];
    assign sclk_rise = ~sclk_sync_q[S] & sclk_sync_q[S-1];
    assign copi_bit  = copi_sync_q[S];

    // ------------------------------------------------------------------
    // Frame FSM and register file
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];

    logic        len_ok, addr_ok, is_write, do_write, silent_read;

    assign len_ok      = (bit_cnt_q == 5'd16) && !ovf_q;
    assign addr_ok     = (shift_q[14:8] <= MAX_ADDR_L);
    assign is_write    = shift_q[15];
    assign do_write    = len_ok && addr_ok && is_write;
    // A well-formed read never changes registers and never flags an error.
    assign silent_read = len_ok && addr_ok && !is_write;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ovf_d     = ovf_q;
        regs_d    = regs_q;
        frame_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // sclk activity here is ignored.
                if (ncs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 5'd0;
                    shift_d   = 16'h0000;
                    ovf_d     = 1'b0;
                end
            end
            ST_SHIFT: begin
                // An ncs rise takes priority over a coincident sclk rise.
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_bit};
                    if (bit_cnt_q == 5'd16) begin
                        ovf_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_COMMIT: begin
                // This state lasts one cycle. Any ncs fall seen here is dropped.
                state_d = ST_IDLE;
                if (do_write) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (shift_q[14:8] == 7'(i)) begin
                            regs_d[i] = shift_q[7:0];
                        end
                    end
                end else if (!silent_read) begin
                    frame_err = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 16'h0000;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ovf_q       <= ovf_d;
            regs_q      <= regs_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
    // ------------------------------------------------------------------
    // Readback. After the 8th rising edge, shift_q[7] holds R/W and
    // shift_q[6:0] holds the address. cipo changes on sclk falls, so the
    // controller samples it on the next rise.
    // ------------------------------------------------------------------
    logic       sclk_fall;
    logic       cipo_q, cipo_d;
    logic [6:0] rd_q, rd_d;
    logic [7:0] rd_val;

    assign sclk_fall = sclk_sync_q[S] & ~sclk_sync_q[S-1];

    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_q[6:0] == 7'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        cipo_d = cipo_q;
        rd_d   = rd_q;
        if (state_q != ST_SHIFT) begin
            cipo_d = 1'b0;
            rd_d   = 7'h00;
        end else if (sclk_fall) begin
            if (bit_cnt_q == 5'd8) begin
                if (!shift_q[7] && (shift_q[6:0] <= MAX_ADDR_L)) begin
                    cipo_d = rd_val[7];
                    rd_d   = rd_val[6:0];
                end else begin
                    cipo_d = 1'b0;
                    rd_d   = 7'h00;
                end
            end else if (bit_cnt_q > 5'd8 && bit_cnt_q < 5'd16) begin
                cipo_d = rd_q[6];
                rd_d   = {rd_q[5:0], 1'b0};
            end else begin
                cipo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cipo_q <= 1'b0;
            rd_q   <= 7'h00;
        end else begin
            cipo_q <= cipo_d;
            rd_q   <= rd_d;
        end
    end

    assign cipo = cipo_q;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
module tb_spi_reg_peripheral;

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic frame_err;
`ifdef SPI_READBACK_EN
  logic cipo;
`endif

  spi_reg_peripheral dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_err       (frame_err)
`ifdef SPI_READBACK_EN
    ,
    .cipo            (cipo)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: {expected frame_err pulse count (0/1), expected registers}
  logic [40:0] exp_q[$];
`ifdef SPI_READBACK_EN
  logic [0:0]  cipo_exp_q[$];
`endif
  logic [39:0] mdl_regs;
  logic [39:0] prev_regs;
  logic [39:0] dut_regs;

  assign dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: mode 0, sclk = clk/10, MSB first
  task automatic send_frame(input logic [31:0] bits, input int nbits);
    ncs = 1'b0;
    wait_clk(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = 1'b0;
      copi = bits[i];
      wait_clk(5);
`ifdef SPI_READBACK_EN
      if ((nbits - 1 - i) >= 8 && cipo_exp_q.size() > 0) begin
        logic [0:0] eb;
        eb = cipo_exp_q.pop_front();
        check_eq("cipo_bit", {39'd0, cipo}, {39'd0, eb});
      end
`endif
      sclk = 1'b1;
      wait_clk(5);
    end
    sclk = 1'b0;
    copi = 1'b0;
    wait_clk(5);
    ncs = 1'b1;
  endtask

  // monitor: watches 12 cycles after the ncs rise, then pops and compares
  task automatic collect(input string tag);
    logic [40:0] e;
    int errs;
    errs = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (frame_err) errs++;
      if (c == 3) check_eq({tag, "_pre_latency"}, dut_regs, prev_regs);
      if (c == 4 && exp_q.size() > 0) check_eq({tag, "_at_latency"}, dut_regs, exp_q[0][39:0]);
    end
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb_empty got=0 exp=1", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_regs"}, dut_regs, e[39:0]);
      check_eq({tag, "_frame_err"}, 40'(errs), {39'd0, e[40]});
    end
  endtask

  // reference model + stimulus
  task automatic do_frame(input string tag, input logic [31:0] bits, input int nbits);
    logic [15:0] f;
    int addr;
    logic err;
    f = bits[15:0];
    addr = int'(f[14:8]);
    prev_regs = mdl_regs;
    err = 1'b1;
    if (nbits == 16 && addr <= 4) begin
      err = 1'b0;
      if (f[15]) mdl_regs[addr*8 +: 8] = f[7:0];
`ifdef SPI_READBACK_EN
      else for (int b = 7; b >= 0; b--) cipo_exp_q.push_back(mdl_regs[addr*8 + b]);
`endif
    end
    exp_q.push_back({err, mdl_regs});
    send_frame(bits, nbits);
    collect(tag);
  endtask

  initial begin
    int errs;
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    mdl_regs = 40'd0;
    wait_clk(3);
    rst = 1'b0;

    // reset state and idle period
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_err) errs++;
    end
    check_eq("reset_regs", dut_regs, 40'd0);
    check_eq("idle_frame_err", 40'(errs), 40'd0);

    do_frame("wr_a0",    32'h80F0, 16);
    do_frame("wr_a4",    32'h8480, 16);
    do_frame("wr_a3",    32'h8355, 16);
    do_frame("bad_addr", 32'h85AA, 16);
    do_frame("short15",  32'h8155 >> 1, 15);
    do_frame("long17",   {15'd0, 16'h8155, 1'b1}, 17);
    do_frame("wr_a2",    32'h82A5, 16);
    do_frame("read_a2",  32'h0200, 16);
    do_frame("read_bad", 32'h0700, 16);

    for (int k = 0; k < 4; k++) begin
      logic [15:0] fr;
      fr = {1'b1, 7'($urandom_range(0, 6)), 8'($urandom_range(0, 255))};
      do_frame("rand_wr", {16'd0, fr}, 16);
    end

    // reset clears everything
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    mdl_regs = 40'd0;
    wait_clk(2);
    check_eq("post_reset_regs", dut_regs, mdl_regs);
    check_eq("post_reset_frame_err", {39'd0, frame_err}, 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // absolute time limit
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
